imm_gen_stage: RTL

- Decode-side immediate generator for the dynamic pipeline.
- Accepts instruction words from IF/ID over valid/ready and classifies the opcode (sign-extend, zero-extend, LUI, none).
- Produces the 32-bit extended immediate, registered, toward ID/EX.
- A 2-entry skid buffer decouples back-pressure so in_ready is fully registered. A flush input drops in-flight work on branch/exception redirect.

---
 rtl/imm_gen_pkg.sv | 62 ++++++
 rtl/imm_skid_buf.sv | 75 +++++++
 rtl/imm_gen_stage.sv | 56 +++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// Shared opcodes, immediate-kind codes, skid-buffer states and the immediate decode function.
// IMM_BR_SHIFT_EN: when defined, BEQ/BNE immediates come out pre-shifted into a byte offset.
package imm_gen_pkg;

    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_SEXT = 2'd1;
    localparam logic [1:0] KIND_ZEXT = 2'd2;
    localparam logic [1:0] KIND_LUI  = 2'd3;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    typedef struct packed {
        logic [31:0] imm;
        logic [1:0]  kind;
    } imm_res_t;

    function automatic imm_res_t imm_decode(input logic [31:0] instr);
        imm_res_t   r;
        logic [15:0] f;
        f      = instr[15:0];
        r.imm  = '0;
        r.kind = KIND_NONE;
        case (instr[31:26])
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
                r.kind = KIND_SEXT;
                r.imm  = {{16{f[15]}}, f};
            end
            OP_BEQ, OP_BNE: begin
                r.kind = KIND_SEXT;
`ifdef IMM_BR_SHIFT_EN
                r.imm  = {{14{f[15]}}, f, 2'b00};
`else
                r.imm  = {{16{f[15]}}, f};
`endif
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                r.kind = KIND_ZEXT;
                r.imm  = {16'h0000, f};
            end
            OP_LUI: begin
                r.kind = KIND_LUI;
                r.imm  = {f, 16'h0000};
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with a fully registered in_ready and synchronous flush.
module imm_skid_buf
    import imm_gen_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    state_t       state;
    logic [W-1:0] skid;
    logic         in_xfer;
    logic         out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // out_data is the main register; skid only ever holds the entry behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid      <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (out_xfer && in_xfer) begin
                        out_data <= in_data;
                    end else if (out_xfer) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end else if (in_xfer) begin
                        skid     <= in_data;
                        in_ready <= 1'b0;
                        state    <= ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        out_data <= skid;
                        in_ready <= 1'b1;
                        state    <= ST_ONE;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-side immediate generator: classify opcode, extend imm, register toward ID/EX via skid buffer.
// IMM_BR_SHIFT_EN (optional) pre-shifts branch immediates by 2.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_imm,
    output logic [1:0]        out_kind,
    output logic [ADDR_W-1:0] out_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int W = 32 + 2 + ADDR_W;

    imm_res_t     dec;
    logic [W-1:0] in_data;
    logic [W-1:0] out_data;

    // Extension happens before the register so out_* is purely registered.
    assign dec     = imm_decode(in_instr);
    assign in_data = {dec.imm, dec.kind, in_pc};

    imm_skid_buf #(.W(W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign {out_imm, out_kind, out_pc} = out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
